// File: rtl/bool_q1_eval.sv
// bool_q1_eval
// Evaluates F = A&B | ~A&C (a 2:1 mux: A selects B, otherwise C) three
// independent ways -- dataflow, behavioral and gate-level structural --
// registers all three results and reports whether they agree.
//
// Ports:
//   clk             rising-edge clock
//   rst             synchronous active-high reset (priority over in_valid)
//   A, B, C         function inputs, sampled when in_valid=1
//   in_valid        A/B/C are valid this cycle
//   F_dataflow      registered dataflow result
//   F_behavioral    registered behavioral result
//   F_structural    registered structural result
//   out_valid       registered results belong to a sample taken last edge
//   match           all three registered results are equal (combinational)
//   mismatch_sticky set once a valid output disagreed; cleared only by rst
module bool_q1_eval (
  input  logic clk,
  input  logic rst,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic in_valid,
  output logic F_dataflow,
  output logic F_behavioral,
  output logic F_structural,
  output logic out_valid,
  output logic match,
  output logic mismatch_sticky
);

  logic f_df;
  logic f_beh;
  logic f_str;
  logic notA;
  logic t1;
  logic t2;

  // Dataflow core
  assign f_df = (A & B) | (~A & C);

  // Behavioral core: minterms 1,3,6,7 of {A,B,C} are true
  always_comb begin
    f_beh = 1'b0;
    case ({A, B, C})
      3'b001:  f_beh = 1'b1;
      3'b011:  f_beh = 1'b1;
      3'b110:  f_beh = 1'b1;
      3'b111:  f_beh = 1'b1;
      default: f_beh = 1'b0;
    endcase
  end

  // Structural core
  not u_not_a (notA, A);
  and u_and_t1 (t1, A, B);
  and u_and_t2 (t2, notA, C);
  or  u_or_f   (f_str, t1, t2);

  // Result registers hold their value through idle cycles; only out_valid
  // says whether they are fresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      F_dataflow      <= 1'b0;
      F_behavioral    <= 1'b0;
      F_structural    <= 1'b0;
      out_valid       <= 1'b0;
      mismatch_sticky <= 1'b0;
    end else begin
      if (in_valid) begin
        F_dataflow   <= f_df;
        F_behavioral <= f_beh;
        F_structural <= f_str;
      end
      out_valid <= in_valid;
      if (out_valid && !match) begin
        mismatch_sticky <= 1'b1;
      end
    end
  end

  // All registers clear to 0 on reset, so match reads 1 after reset.
  assign match = (F_dataflow == F_behavioral) && (F_behavioral == F_structural);

endmodule

// File: tb/tb_bool_q1_eval.sv
// tb_bool_q1_eval
// Directed plan steps plus a randomized stream, every cycle compared against
// a truth-table reference model held in the bench.
module tb_bool_q1_eval;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic A = 1'b0;
  logic B = 1'b0;
  logic C = 1'b0;
  logic in_valid = 1'b0;
  logic F_dataflow;
  logic F_behavioral;
  logic F_structural;
  logic out_valid;
  logic match;
  logic mismatch_sticky;

  int total = 0;
  int bad = 0;

  // Reference truth table indexed by {A,B,C}
  bit truth_tbl [8] = '{0, 1, 0, 1, 0, 0, 1, 1};

  // Model state
  bit exp_df = 0, exp_beh = 0, exp_str = 0, exp_valid = 0, exp_sticky = 0;
  bit fault_t1 = 0;

  bool_q1_eval dut (
    .clk(clk),
    .rst(rst),
    .A(A),
    .B(B),
    .C(C),
    .in_valid(in_valid),
    .F_dataflow(F_dataflow),
    .F_behavioral(F_behavioral),
    .F_structural(F_structural),
    .out_valid(out_valid),
    .match(match),
    .mismatch_sticky(mismatch_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%b want=%b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model across the edge, compare.
  task automatic step(input bit r, input bit v, input bit [2:0] abc);
    int idx;
    bit exp_match_before;
    rst = r;
    in_valid = v;
    {A, B, C} = abc;
    idx = int'(abc);
    exp_match_before = (exp_df == exp_beh) && (exp_beh == exp_str);
    @(posedge clk);
    #1;
    if (r) begin
      exp_df = 0; exp_beh = 0; exp_str = 0; exp_valid = 0; exp_sticky = 0;
    end else begin
      if (exp_valid && !exp_match_before) exp_sticky = 1;
      if (v) begin
        exp_df  = truth_tbl[idx];
        exp_beh = truth_tbl[idx];
        // With t1 stuck at 0 only the ~A&C term survives
        exp_str = fault_t1 ? (!abc[2] && abc[0]) : truth_tbl[idx];
      end
      exp_valid = v;
    end
    check("F_dataflow", F_dataflow, exp_df);
    check("F_behavioral", F_behavioral, exp_beh);
    check("F_structural", F_structural, exp_str);
    check("out_valid", out_valid, exp_valid);
    check("match", match, (exp_df == exp_beh) && (exp_beh == exp_str));
    check("mismatch_sticky", mismatch_sticky, exp_sticky);
    $display("cyc rst=%0b v=%0b abc=%03b -> df=%0b bh=%0b st=%0b ov=%0b m=%0b stk=%0b",
             r, v, abc, F_dataflow, F_behavioral, F_structural, out_valid, match,
             mismatch_sticky);
  endtask

  initial begin
    // Reset for two cycles
    step(1, 0, 3'b000);
    step(1, 1, 3'b111);

    // Exhaustive back-to-back sweep
    for (int i = 0; i < 8; i++) step(0, 1, 3'(i));

    // Hold: inputs change while in_valid=0
    step(0, 1, 3'b110);
    step(0, 0, 3'b001);
    step(0, 0, 3'b001);

    // Mux spot checks
    step(0, 1, 3'b101);
    step(0, 1, 3'b001);
    step(0, 1, 3'b110);

    // Mid-stream reset discards the in-flight 111
    step(0, 1, 3'b000);
    A = 1'b1; B = 1'b1; C = 1'b1; in_valid = 1'b1; rst = 1'b1;
    step(1, 1, 3'b111);
    step(0, 0, 3'b111);

    // Mismatch detection with t1 stuck low in the structural core
    fault_t1 = 1;
    force dut.t1 = 1'b0;
    step(0, 1, 3'b110);
    release dut.t1;
    fault_t1 = 0;
    step(0, 0, 3'b000);
    step(0, 1, 3'b111);
    step(0, 1, 3'b010);
    step(1, 0, 3'b000);
    step(0, 0, 3'b000);

    // Randomized stream
    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(0, 24) == 0), bit'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety bound so the run always terminates
  initial begin
    #100000;
    bad++;
    $display("FAIL timeout: got=running want=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
